i2s_slave_trx: RTL and testbench

- I2S transceiver in slave mode. LRCK and SCLK are inputs driven by an external master, such as a codec in master mode or another board's i2s_trx.
- Oversamples LRCK, SCLK and SDATA in the mclk_in domain and deserialises stereo RX words.
- Serialises stereo TX words with standard I2S one-bit MSB delay.
- Presents the same parallel interface as the master transceiver, plus frame strobes, so DSP blocks work with either clocking role.

---
 rtl/i2s_slave_trx_pkg.sv | 22 ++
 rtl/i2s_slave_trx_sync_edge.sv | 50 +++++
 rtl/i2s_slave_trx.sv | 144 ++++++++++++++
 tb/tb_i2s_slave_trx.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_slave_trx_pkg.sv
// Shared constants and sizing helpers for the slave-mode I2S transceiver.
package i2s_pkg;

    // LRCK level meaning: low selects the left channel, high the right.
    localparam logic LRCK_LEFT  = 1'b0;
    localparam logic LRCK_RIGHT = 1'b1;

    // Each SCLK phase must last at least this many mclk cycles so that the
    // synchroniser plus edge-detect flop can resolve every transition.
    localparam int DEFAULT_SYNC_STAGES = 2;
    localparam int MIN_SCLK_PHASE      = DEFAULT_SYNC_STAGES + 2;

    function automatic int min_sclk_phase(input int sync_stages);
        return sync_stages + 2;
    endfunction

    // Bit counters must be able to hold PDATA_WIDTH itself (saturation value).
    function automatic int bit_cnt_width(input int pdata_width);
        return $clog2(pdata_width + 1);
    endfunction

endpackage

// File: rtl/i2s_slave_trx_sync_edge.sv
// Multi-flop synchroniser with optional rise/fall pulse generation.
module i2s_sync_edge
    import i2s_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter bit EDGE_DETECT = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_reg;

    // Shift the asynchronous input through the synchroniser chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_reg[SYNC_STAGES-1];

    generate
        if (EDGE_DETECT) begin : g_edge
            logic prev_reg;

            // One extra flop of the synchronised level gives single-cycle edge pulses.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    prev_reg <= 1'b0;
                end else begin
                    prev_reg <= q;
                end
            end

            assign rise = q & ~prev_reg;
            assign fall = ~q & prev_reg;
        end else begin : g_no_edge
            assign rise = 1'b0;
            assign fall = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/i2s_slave_trx.sv
// Slave-mode I2S transceiver: LRCK/SCLK come from an external master and are
// oversampled on mclk_in; stereo words are deserialised and serialised with
// the standard one-bit MSB delay.
module i2s_slave_trx
    import i2s_pkg::*;
#(
    parameter int PDATA_WIDTH = 32,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic                   mclk_in,
    input  logic                   arst_in,
    input  logic                   lrck_in,
    input  logic                   sclk_in,
    input  logic                   sdata_in,
    output logic [PDATA_WIDTH-1:0] pldata_out,
    output logic [PDATA_WIDTH-1:0] prdata_out,
    output logic                   rx_valid_out,
    output logic                   sdata_out,
    input  logic [PDATA_WIDTH-1:0] pldata_in,
    input  logic [PDATA_WIDTH-1:0] prdata_in,
    output logic                   tx_load_out
);

    localparam int                     CW       = bit_cnt_width(PDATA_WIDTH);
    localparam logic [CW-1:0]          CNT_FULL = CW'(PDATA_WIDTH);
    localparam logic [PDATA_WIDTH-1:0] MSB_MASK = {1'b1, {(PDATA_WIDTH-1){1'b0}}};

    logic sclk_level_unused, sclk_rise, sclk_fall;
    logic lrck_q, lrck_rise_unused, lrck_fall_unused;
    logic sdata_q, sdata_rise_unused, sdata_fall_unused;

    // All three inputs see identical synchroniser delay so data stays aligned to SCLK.
    i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_DETECT(1'b1)) u_sync_sclk (
        .clk(mclk_in), .rst(arst_in), .d(sclk_in),
        .q(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
    );
    i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_DETECT(1'b1)) u_sync_lrck (
        .clk(mclk_in), .rst(arst_in), .d(lrck_in),
        .q(lrck_q), .rise(lrck_rise_unused), .fall(lrck_fall_unused)
    );
    i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_DETECT(1'b0)) u_sync_sdata (
        .clk(mclk_in), .rst(arst_in), .d(sdata_in),
        .q(sdata_q), .rise(sdata_rise_unused), .fall(sdata_fall_unused)
    );

    logic                   lrck_prev_reg, armed_reg;
    logic [PDATA_WIDTH-1:0] rx_shift_reg, l_stage_reg, r_stage_reg;
    logic [CW-1:0]          rx_cnt_reg, tx_cnt_reg;
    logic                   l_staged_reg, pair_pending_reg;
    logic [PDATA_WIDTH-1:0] hold_l_reg, hold_r_reg;
    logic                   tx_chan_reg;

    logic                   lrck_change;
    logic [PDATA_WIDTH-1:0] rx_word_next, tx_word, rx_mask, tx_mask;
    logic                   tx_bit_next;

    // Current sample merged into the shift word; a saturated counter shifts the mask out, so no write happens.
    always_comb begin
        lrck_change  = sclk_rise && (lrck_q != lrck_prev_reg);
        rx_mask      = MSB_MASK >> rx_cnt_reg;
        rx_word_next = sdata_q ? (rx_shift_reg | rx_mask) : (rx_shift_reg & ~rx_mask);
        tx_word      = (tx_chan_reg == LRCK_RIGHT) ? hold_r_reg : hold_l_reg;
        tx_mask      = MSB_MASK >> tx_cnt_reg;
        tx_bit_next  = |(tx_word & tx_mask);
    end

    // RX: channel tracking, arming, deserialising and pairing of left/right words.
    always_ff @(posedge mclk_in or posedge arst_in) begin
        if (arst_in) begin
            lrck_prev_reg    <= LRCK_LEFT;
            armed_reg        <= 1'b0;
            rx_shift_reg     <= '0;
            rx_cnt_reg       <= '0;
            l_stage_reg      <= '0;
            r_stage_reg      <= '0;
            l_staged_reg     <= 1'b0;
            pair_pending_reg <= 1'b0;
            pldata_out       <= '0;
            prdata_out       <= '0;
            rx_valid_out     <= 1'b0;
        end else begin
            rx_valid_out <= 1'b0;
            if (pair_pending_reg) begin
                pldata_out       <= l_stage_reg;
                prdata_out       <= r_stage_reg;
                rx_valid_out     <= 1'b1;
                pair_pending_reg <= 1'b0;
            end
            if (lrck_change) begin
                // The bit sampled here is the previous slot's LSB; it completes that word.
                lrck_prev_reg <= lrck_q;
                armed_reg     <= 1'b1;
                rx_cnt_reg    <= '0;
                rx_shift_reg  <= '0;
                if (armed_reg) begin
                    if (lrck_prev_reg == LRCK_LEFT) begin
                        l_stage_reg  <= rx_word_next;
                        l_staged_reg <= 1'b1;
                    end else if (l_staged_reg) begin
                        r_stage_reg      <= rx_word_next;
                        l_staged_reg     <= 1'b0;
                        pair_pending_reg <= 1'b1;
                    end
                end
            end else if (sclk_rise && armed_reg) begin
                rx_shift_reg <= rx_word_next;
                if (rx_cnt_reg < CNT_FULL) begin
                    rx_cnt_reg <= rx_cnt_reg + CW'(1);
                end
            end
        end
    end

    // TX: latch both words at each left-channel start, then shift MSB first on SCLK falls.
    always_ff @(posedge mclk_in or posedge arst_in) begin
        if (arst_in) begin
            hold_l_reg  <= '0;
            hold_r_reg  <= '0;
            tx_chan_reg <= LRCK_LEFT;
            tx_cnt_reg  <= '0;
            tx_load_out <= 1'b0;
            sdata_out   <= 1'b0;
        end else begin
            tx_load_out <= 1'b0;
            if (lrck_change) begin
                tx_chan_reg <= lrck_q;
                tx_cnt_reg  <= '0;
                if (armed_reg && lrck_q == LRCK_LEFT) begin
                    hold_l_reg  <= pldata_in;
                    hold_r_reg  <= prdata_in;
                    tx_load_out <= 1'b1;
                end
            end else if (sclk_fall && armed_reg) begin
                if (tx_cnt_reg < CNT_FULL) begin
                    sdata_out  <= tx_bit_next;
                    tx_cnt_reg <= tx_cnt_reg + CW'(1);
                end else begin
                    sdata_out <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_slave_trx.sv
// Scoreboard bench for i2s_slave_trx: an external I2S master is modelled as a
// per-SCLK-period stream built from slot descriptions; expected RX pairs and
// expected TX bits at each SCLK rise come from a slot-level reference model.
module tb_i2s_slave_trx;

    localparam int W = 32;

    logic         mclk_in = 1'b0;
    logic         arst_in = 1'b1;
    logic         lrck_in = 1'b0;
    logic         sclk_in = 1'b0;
    logic         m_sdata = 1'b0;
    logic         loop_mode = 1'b0;
    logic         sdata_in;
    logic [W-1:0] pldata_out, prdata_out, pldata_in, prdata_in;
    logic         rx_valid_out, sdata_out, tx_load_out;

    assign sdata_in = loop_mode ? sdata_out : m_sdata;

    always #5 mclk_in = ~mclk_in;

    i2s_slave_trx #(.PDATA_WIDTH(W), .SYNC_STAGES(2)) dut (
        .mclk_in(mclk_in), .arst_in(arst_in), .lrck_in(lrck_in), .sclk_in(sclk_in),
        .sdata_in(sdata_in), .pldata_out(pldata_out), .prdata_out(prdata_out),
        .rx_valid_out(rx_valid_out), .sdata_out(sdata_out), .pldata_in(pldata_in),
        .prdata_in(prdata_in), .tx_load_out(tx_load_out)
    );

    int checks = 0;
    int failures = 0;

    logic [63:0] exp_q[$];
    bit          lr_a[$];
    bit          db_a[$];
    bit          tx_a[8192];
    int          nper;

    // Reference model state (slot level)
    bit          m_armed, m_prev, m_lvalid;
    logic [31:0] m_lstage, m_prev_cap, m_txl, m_txr;
    int          m_loads = 0;
    int          up_loads = 0;
    int          load_base = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] tx_l(input int k);
        return 32'(k + 1 - load_base);
    endfunction

    function automatic logic [31:0] tx_r(input int k);
        return loop_mode ? 32'hA5A5A5A5 : (32'h5A5A0000 ^ (32'(k) * 32'h01030507));
    endfunction

    // First 32 bits of an n-bit slot (value in low n bits), left aligned.
    function automatic logic [31:0] capture(input logic [63:0] v, input int n);
        logic [63:0] t;
        t = v << (64 - n);
        return t[63:32];
    endfunction

    task automatic new_stream();
        lr_a.delete();
        db_a.delete();
        foreach (tx_a[i]) tx_a[i] = 1'b0;
        nper = 0;
    endtask

    task automatic model_reset();
        m_armed = 1'b0; m_prev = 1'b0; m_lvalid = 1'b0;
        m_lstage = '0; m_prev_cap = '0; m_txl = '0; m_txr = '0;
    endtask

    // Append one slot of n SCLK periods on channel c carrying v (MSB first).
    task automatic add_slot(input bit c, input logic [63:0] v, input int n);
        int          start;
        logic [31:0] txw;
        logic [63:0] rxv;
        start = nper;
        if (c != m_prev) begin
            if (m_armed) begin
                if (m_prev == 1'b0) begin
                    m_lstage = m_prev_cap;
                    m_lvalid = 1'b1;
                end else if (m_lvalid) begin
                    exp_q.push_back({m_lstage, m_prev_cap});
                    m_lvalid = 1'b0;
                end
                if (c == 1'b0) begin
                    m_txl = tx_l(m_loads);
                    m_txr = tx_r(m_loads);
                    m_loads++;
                end
            end else begin
                m_armed = 1'b1;
            end
            m_prev = c;
        end
        txw = !m_armed ? 32'h0 : (c ? m_txr : m_txl);
        rxv = loop_mode ? {32'h0, txw} : v;
        m_prev_cap = capture(rxv, n);
        for (int k = 0; k < n; k++) begin
            lr_a.push_back(c);
            db_a.push_back(rxv[n-1-k]);
            tx_a[start+k+1] = (k < W) ? txw[W-1-k] : 1'b0;
        end
        nper += n;
    endtask

    // Drive the stream: LRCK/data change on SCLK fall, sdata_out sampled just before each rise.
    task automatic play();
        for (int p = 0; p < nper; p++) begin
            @(negedge mclk_in);
            sclk_in = 1'b0;
            lrck_in = lr_a[p];
            m_sdata = (p == 0) ? 1'b0 : db_a[p-1];
            repeat (4) @(negedge mclk_in);
            chk("sdata_out_at_rise", {63'h0, sdata_out}, {63'h0, tx_a[p]});
            sclk_in = 1'b1;
            repeat (3) @(negedge mclk_in);
        end
        repeat (12) @(negedge mclk_in);
    endtask

    task automatic do_reset(input bit check_outputs, input bit loop);
        @(negedge mclk_in);
        arst_in = 1'b1;
        repeat (3) @(negedge mclk_in);
        if (check_outputs) begin
            chk("reset_pldata_out", pldata_out, 0);
            chk("reset_prdata_out", prdata_out, 0);
            chk("reset_rx_valid_out", rx_valid_out, 0);
            chk("reset_sdata_out", sdata_out, 0);
            chk("reset_tx_load_out", tx_load_out, 0);
        end
        loop_mode = loop;
        if (loop) load_base = m_loads;
        model_reset();
        @(negedge mclk_in);
        arst_in = 1'b0;
    endtask

    task automatic drained(input string name);
        chk(name, 64'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    // Upstream TX source: presents the next word pair after each load strobe.
    initial begin
        forever begin
            @(negedge mclk_in);
            if (tx_load_out === 1'b1) up_loads++;
            pldata_in = tx_l(up_loads);
            prdata_in = tx_r(up_loads);
        end
    end

    // RX monitor: every rx_valid_out pulse must match the oldest expected pair.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge mclk_in);
            if (rx_valid_out === 1'b1) begin
                $display("rx pair L=%h R=%h", pldata_out, prdata_out);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rx_valid actual=%h_%h expected=no_pulse", pldata_out, prdata_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("rx_left", {32'h0, pldata_out}, {32'h0, e[63:32]});
                    chk("rx_right", {32'h0, prdata_out}, {32'h0, e[31:0]});
                end
            end
        end
    end

    initial begin
        pldata_in = tx_l(0);
        prdata_in = tx_r(0);
        model_reset();
        do_reset(1'b1, 1'b0);

        // Fixed-pattern frame, then a random frame; lone arming right slot is discarded.
        new_stream();
        add_slot(1'b0, 64'($urandom), 4);
        add_slot(1'b1, 64'($urandom), 32);
        add_slot(1'b0, 64'h12345678, 32);
        add_slot(1'b1, 64'h9ABCDEF0, 32);
        add_slot(1'b0, 64'($urandom), 32);
        add_slot(1'b1, 64'($urandom), 32);
        add_slot(1'b0, 64'($urandom), 2);
        play();
        drained("pairs_drained_32bit");

        // 24-bit slots: words arrive left aligned with zero LSBs.
        do_reset(1'b0, 1'b0);
        new_stream();
        add_slot(1'b0, 64'($urandom), 4);
        add_slot(1'b1, 64'($urandom), 24);
        add_slot(1'b0, 64'hABCDEF, 24);
        add_slot(1'b1, 64'($urandom), 24);
        add_slot(1'b0, 64'($urandom), 24);
        add_slot(1'b1, 64'($urandom), 24);
        add_slot(1'b0, 64'($urandom), 2);
        play();
        drained("pairs_drained_24bit");

        // 40-bit slots: only the first 32 bits are captured, TX pads with zeros.
        do_reset(1'b0, 1'b0);
        new_stream();
        add_slot(1'b0, 64'($urandom), 4);
        add_slot(1'b1, {$urandom, $urandom}, 40);
        for (int f = 0; f < 2; f++) begin
            add_slot(1'b0, {$urandom, $urandom}, 40);
            add_slot(1'b1, {$urandom, $urandom}, 40);
        end
        add_slot(1'b0, 64'($urandom), 2);
        play();
        drained("pairs_drained_40bit");

        // Reset in the middle of a right slot, then a fresh stream after release.
        do_reset(1'b0, 1'b0);
        new_stream();
        add_slot(1'b0, 64'($urandom), 4);
        add_slot(1'b1, 64'($urandom), 32);
        add_slot(1'b0, 64'($urandom), 32);
        add_slot(1'b1, 64'($urandom), 32);
        add_slot(1'b0, 64'($urandom), 32);
        add_slot(1'b1, 64'($urandom), 16);
        play();
        drained("pairs_drained_before_reset");
        do_reset(1'b1, 1'b0);
        new_stream();
        add_slot(1'b1, 64'($urandom), 10);
        add_slot(1'b0, 64'($urandom), 32);
        add_slot(1'b1, 64'($urandom), 32);
        add_slot(1'b0, 64'($urandom), 2);
        play();
        drained("pairs_drained_after_reset");

        // Loopback: sdata_out feeds sdata_in across 16 frames.
        do_reset(1'b0, 1'b1);
        new_stream();
        add_slot(1'b0, 64'h0, 4);
        add_slot(1'b1, 64'h0, 32);
        for (int f = 0; f < 16; f++) begin
            add_slot(1'b0, 64'h0, 32);
            add_slot(1'b1, 64'h0, 32);
        end
        add_slot(1'b0, 64'h0, 2);
        play();
        drained("pairs_drained_loopback");

        chk("tx_load_count", 64'(up_loads), 64'(m_loads));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
